// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32 control path:
// opcodes, ALU ops, FSM states and write-back selects.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WRITEBACK
  } state_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10,
    WB_IMM = 2'b11
  } wb_sel_e;

  typedef struct packed {
    logic [6:0] func7;
    logic [2:0] func3;
    logic [6:0] opcode;
  } ctrl_fields_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational opcode/func3/func7 decode into ALU op,
// operand-B select and an illegal-instruction flag.
module alu_decoder
  import riscv_ctrl_pkg::*;
#(
  parameter bit SUPPORT_SRAI = 1'b1
) (
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  output alu_op_e    alu_op,
  output logic       sel_bw_imm_rs2,
  output logic       illegal
);

  logic is_r;
  logic alt;
  logic f7_ok;

  assign is_r  = (opcode == OP_R);
  assign alt   = (func7 == F7_ALT);
  assign f7_ok = (func7 == F7_BASE) || alt;

  always_comb begin
    alu_op         = ALU_ADD;
    sel_bw_imm_rs2 = 1'b1;
    illegal        = 1'b0;
    unique case (1'b1)
      opcode == OP_R,
      opcode == OP_IMM: begin
        sel_bw_imm_rs2 = is_r;
        unique case (func3)
          3'b000: begin
            // I-type func7 bits are immediate, so only R checks them
            alu_op  = (is_r && alt) ? ALU_SUB : ALU_ADD;
            illegal = is_r && !f7_ok;
          end
          3'b001: begin
            alu_op  = ALU_SLL;
            illegal = !f7_ok;
          end
          3'b010: alu_op = ALU_SLT;
          3'b011: alu_op = ALU_SLTU;
          3'b100: alu_op = ALU_XOR;
          3'b101: begin
            alu_op  = alt ? ALU_SRA : ALU_SRL;
            illegal = !f7_ok
                   || (!is_r && alt && !SUPPORT_SRAI);
          end
          3'b110: alu_op = ALU_OR;
          default: alu_op = ALU_AND;
        endcase
      end
      opcode == OP_LOAD,
      opcode == OP_STORE,
      opcode == OP_JAL,
      opcode == OP_LUI: sel_bw_imm_rs2 = 1'b0;
      opcode == OP_BRANCH: begin
        alu_op  = ALU_SUB;
        illegal = (func3[2:1] != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Five-state multicycle control FSM: fetch, decode,
// execute, memory access and register write-back.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int INSTR_WIDTH  = 32,
  parameter int ALU_OP_WIDTH = 4,
  parameter bit SUPPORT_SRAI = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [INSTR_WIDTH-1:0]  instruction,
  input  logic                    imem_ack,
  input  logic                    dmem_ack,
  input  logic                    alu_zero,
  output logic                    imem_req,
  output logic                    dmem_req,
  output logic                    dmem_read_en,
  output logic                    dmem_write_en,
  output logic [ALU_OP_WIDTH-1:0] alu_op,
  output logic                    sel_bw_imm_rs2,
  output logic                    regfile_write_enable,
  output logic [1:0]              wr_back_sel,
  output logic                    ir_write,
  output logic                    pc_write,
  output logic                    pc_src,
  output logic                    illegal_instr
);

  state_e       state;
  state_e       state_nxt;
  logic         active;
  ctrl_fields_t ir;
  ctrl_fields_t fld;
  ctrl_fields_t dec_in;
  alu_op_e      dec_op;
  logic         dec_sel;
  logic         dec_ill;
  logic         unused_instr;

  assign unused_instr = ^instruction;

  // active holds requests off for the first cycle after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_FETCH;
      active <= 1'b0;
      ir     <= '0;
      fld    <= '0;
    end else begin
      state  <= state_nxt;
      active <= 1'b1;
      if (ir_write) begin
        ir <= '{func7:  instruction[31:25],
                func3:  instruction[14:12],
                opcode: instruction[6:0]};
      end
      if (state == S_DECODE) fld <= ir;
    end
  end

  assign dec_in = (state == S_DECODE) ? ir : fld;

  alu_decoder #(
    .SUPPORT_SRAI(SUPPORT_SRAI)
  ) u_alu_decoder (
    .opcode        (dec_in.opcode),
    .func3         (dec_in.func3),
    .func7         (dec_in.func7),
    .alu_op        (dec_op),
    .sel_bw_imm_rs2(dec_sel),
    .illegal       (dec_ill)
  );

  logic is_load;
  logic is_store;
  logic is_br;
  logic taken;

  assign is_load  = (fld.opcode == OP_LOAD);
  assign is_store = (fld.opcode == OP_STORE);
  assign is_br    = (fld.opcode == OP_BRANCH);
  assign taken    = fld.func3[0] ? !alu_zero : alu_zero;

  always_comb begin
    state_nxt            = state;
    imem_req             = 1'b0;
    dmem_req             = 1'b0;
    dmem_read_en         = 1'b0;
    dmem_write_en        = 1'b0;
    alu_op               = '0;
    sel_bw_imm_rs2       = 1'b1;
    regfile_write_enable = 1'b0;
    wr_back_sel          = WB_ALU;
    ir_write             = 1'b0;
    pc_write             = 1'b0;
    pc_src               = 1'b0;
    illegal_instr        = 1'b0;
    unique case (state)
      S_FETCH: begin
        imem_req = active;
        if (active && imem_ack) begin
          ir_write  = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec_ill) begin
          illegal_instr = 1'b1;
          pc_write      = 1'b1;
          state_nxt     = S_FETCH;
        end else begin
          state_nxt = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        alu_op         = ALU_OP_WIDTH'(dec_op);
        sel_bw_imm_rs2 = dec_sel;
        unique case (1'b1)
          is_load || is_store: state_nxt = S_MEM;
          is_br: begin
            pc_write  = 1'b1;
            pc_src    = taken;
            state_nxt = S_FETCH;
          end
          default: state_nxt = S_WRITEBACK;
        endcase
      end
      S_MEM: begin
        alu_op         = ALU_OP_WIDTH'(dec_op);
        sel_bw_imm_rs2 = dec_sel;
        dmem_req       = 1'b1;
        dmem_read_en   = is_load;
        dmem_write_en  = is_store;
        if (dmem_ack) begin
          pc_write  = is_store;
          state_nxt = is_load ? S_WRITEBACK : S_FETCH;
        end
      end
      S_WRITEBACK: begin
        alu_op               = ALU_OP_WIDTH'(dec_op);
        sel_bw_imm_rs2       = dec_sel;
        regfile_write_enable = 1'b1;
        pc_write             = 1'b1;
        unique case (fld.opcode)
          OP_LOAD: wr_back_sel = WB_MEM;
          OP_JAL: begin
            wr_back_sel = WB_PC4;
            pc_src      = 1'b1;
          end
          OP_LUI:  wr_back_sel = WB_IMM;
          default: wr_back_sel = WB_ALU;
        endcase
        state_nxt = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller against an
// instruction-level schedule model, SRAI on and off.
module tb_multicycle_controller;

  typedef logic [10:0] ctl_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instruction;
  logic        alu_zero;
  logic        ia_a, da_a, ia_b, da_b;

  logic       imem_req_a, dmem_req_a, rd_a, wr_a;
  logic       imem_req_b, dmem_req_b, rd_b, wr_b;
  logic [3:0] alu_op_a, alu_op_b;
  logic       sel_a, sel_b, we_a, we_b;
  logic [1:0] ws_a, ws_b;
  logic       irw_a, irw_b, pcw_a, pcw_b;
  logic       pcs_a, pcs_b, ill_a, ill_b;

  ctl_t       ctl_a, ctl_b;
  logic [4:0] alu_a, alu_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multicycle_controller #(
    .INSTR_WIDTH(32), .ALU_OP_WIDTH(4), .SUPPORT_SRAI(1'b1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .instruction(instruction),
    .imem_ack(ia_a), .dmem_ack(da_a), .alu_zero(alu_zero),
    .imem_req(imem_req_a), .dmem_req(dmem_req_a),
    .dmem_read_en(rd_a), .dmem_write_en(wr_a),
    .alu_op(alu_op_a), .sel_bw_imm_rs2(sel_a),
    .regfile_write_enable(we_a), .wr_back_sel(ws_a),
    .ir_write(irw_a), .pc_write(pcw_a), .pc_src(pcs_a),
    .illegal_instr(ill_a)
  );

  multicycle_controller #(
    .INSTR_WIDTH(32), .ALU_OP_WIDTH(4), .SUPPORT_SRAI(1'b0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .instruction(instruction),
    .imem_ack(ia_b), .dmem_ack(da_b), .alu_zero(alu_zero),
    .imem_req(imem_req_b), .dmem_req(dmem_req_b),
    .dmem_read_en(rd_b), .dmem_write_en(wr_b),
    .alu_op(alu_op_b), .sel_bw_imm_rs2(sel_b),
    .regfile_write_enable(we_b), .wr_back_sel(ws_b),
    .ir_write(irw_b), .pc_write(pcw_b), .pc_src(pcs_b),
    .illegal_instr(ill_b)
  );

  assign ctl_a = {imem_req_a, irw_a, dmem_req_a, rd_a, wr_a,
                  we_a, ws_a, pcw_a, pcs_a, ill_a};
  assign ctl_b = {imem_req_b, irw_b, dmem_req_b, rd_b, wr_b,
                  we_b, ws_b, pcw_b, pcs_b, ill_b};
  assign alu_a = {alu_op_a, sel_a};
  assign alu_b = {alu_op_b, sel_b};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic ctl_t mk(bit ireq, bit irw, bit dreq, bit rd,
                              bit wr, bit we, logic [1:0] ws,
                              bit pw, bit ps, bit il);
    return {ireq, irw, dreq, rd, wr, we, ws, pw, ps, il};
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // kind: 0 alu, 1 load, 2 store, 3 branch, 4 jal, 5 lui
  function automatic bit model(input logic [31:0] w, input bit srai,
                               output int kind, output logic [3:0] op,
                               output logic sel);
    logic [3:0] amap [8];
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    bit f7ok, shift, legal;
    amap = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    opc = w[6:0];
    f3 = w[14:12];
    f7 = w[31:25];
    f7ok = (f7 == 7'h00) || (f7 == 7'h20);
    shift = (f3 == 3'd1) || (f3 == 3'd5);
    kind = 0;
    op = 4'd0;
    sel = 1'b0;
    legal = 1'b1;
    case (opc)
      7'h33, 7'h13: begin
        op = amap[f3];
        if (f3 == 3'd5 && f7 == 7'h20) op = 4'd7;
        if (opc == 7'h33) begin
          sel = 1'b1;
          if (f3 == 3'd0 && f7 == 7'h20) op = 4'd1;
          if ((shift || f3 == 3'd0) && !f7ok) legal = 1'b0;
        end else begin
          if (shift && !f7ok) legal = 1'b0;
          if (f3 == 3'd5 && f7 == 7'h20 && !srai) legal = 1'b0;
        end
      end
      7'h03: kind = 1;
      7'h23: kind = 2;
      7'h63: begin
        kind = 3;
        op = 4'd1;
        sel = 1'b1;
        legal = (f3 < 3'd2);
      end
      7'h6F: kind = 4;
      7'h37: kind = 5;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

  task automatic step(input bit b, input ctl_t ce, input bit achk,
                      input logic [4:0] ae, input bit ia, input bit da,
                      input bit z, input logic [31:0] ins);
    @(negedge clk);
    instruction = ins;
    alu_zero = z;
    ia_a = b ? 1'b0 : ia;
    da_a = b ? 1'b0 : da;
    ia_b = b ? ia : 1'b0;
    da_b = b ? da : 1'b0;
    #2;
    check(b ? "ctl_b" : "ctl_a", b ? ctl_b : ctl_a, ce);
    if (achk) check(b ? "alu_b" : "alu_a", b ? alu_b : alu_a, ae);
  endtask

  task automatic run(input bit b, input logic [31:0] w, input int wi,
                     input int wd, input bit z);
    int kind;
    logic [3:0] op;
    logic sel;
    logic [4:0] ae;
    logic [1:0] ws;
    bit legal, taken;
    legal = model(w, !b, kind, op, sel);
    ae = {op, sel};
    repeat (wi)
      step(b, mk(1,0,0,0,0,0,2'd0,0,0,0), 0, 5'd0,
           0, rb(), rb(), $urandom);
    step(b, mk(1,1,0,0,0,0,2'd0,0,0,0), 0, 5'd0, 1, rb(), rb(), w);
    if (!legal) begin
      step(b, mk(0,0,0,0,0,0,2'd0,1,0,1), 0, 5'd0,
           rb(), rb(), rb(), $urandom);
      return;
    end
    step(b, '0, 0, 5'd0, rb(), rb(), rb(), $urandom);
    if (kind == 3) begin
      taken = (w[14:12] == 3'd0) ? z : !z;
      step(b, mk(0,0,0,0,0,0,2'd0,1,taken,0), 1, ae,
           rb(), rb(), z, $urandom);
      return;
    end
    step(b, '0, 1, ae, rb(), rb(), z, $urandom);
    if (kind == 1 || kind == 2) begin
      repeat (wd)
        step(b, mk(0,0,1,kind==1,kind==2,0,2'd0,0,0,0), 1, ae,
             rb(), 0, rb(), $urandom);
      step(b, mk(0,0,1,kind==1,kind==2,0,2'd0,kind==2,0,0), 1, ae,
           rb(), 1, rb(), $urandom);
      if (kind == 2) return;
    end
    ws = (kind == 1) ? 2'b01 : (kind == 4) ? 2'b10 :
         (kind == 5) ? 2'b11 : 2'b00;
    step(b, mk(0,0,0,0,0,1,ws,1,kind==4,0), 1, ae,
         rb(), rb(), rb(), $urandom);
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_ctl_a"}, ctl_a, '0);
    check({tag, "_ctl_b"}, ctl_b, '0);
    check({tag, "_alu_a"}, alu_a, 5'b00001);
    check({tag, "_alu_b"}, alu_b, 5'b00001);
  endtask

  task automatic release_reset();
    @(negedge clk);
    ia_a = 0; da_a = 0; ia_b = 0; da_b = 0;
    rst_n = 1'b1;
    #2;
    check("rel_idle_a", ctl_a, '0);
    @(negedge clk);
    #2;
    check("rel_fetch_a", ctl_a, mk(1,0,0,0,0,0,2'd0,0,0,0));
    check("rel_fetch_b", ctl_b, mk(1,0,0,0,0,0,2'd0,0,0,0));
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] opcs [9];
    logic [31:0] w;
    int k;
    opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
             7'h6F, 7'h37, 7'h7F, 7'h00};
    w = $urandom;
    k = $urandom_range(0, 8);
    w[6:0] = (k == 8) ? 7'($urandom) : opcs[k];
    case ($urandom_range(0, 3))
      0, 1: w[31:25] = 7'h00;
      2: w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    rst_n = 1'b0;
    instruction = '0;
    alu_zero = 1'b0;
    ia_a = 0; da_a = 0; ia_b = 0; da_b = 0;
    repeat (3) @(negedge clk);
    #2;
    reset_check("reset");
    release_reset();

    run(0, 32'h002081B3, 0, 0, 0);
    run(0, 32'h0000A183, 1, 3, 0);
    run(0, 32'h00208463, 0, 0, 1);
    run(0, 32'h00208463, 0, 0, 0);
    run(0, 32'h00209463, 2, 0, 0);
    run(0, 32'h0000007F, 0, 0, 0);
    run(0, 32'h0020A023, 0, 2, 0);
    run(0, 32'h008000EF, 0, 0, 0);
    run(0, 32'h000010B7, 0, 0, 0);
    run(0, 32'h4020D093, 0, 0, 0);
    run(1, 32'h4020D093, 0, 0, 0);
    run(1, 32'h40208133, 1, 0, 0);

    // store interrupted by reset while waiting on dmem
    step(0, mk(1,1,0,0,0,0,2'd0,0,0,0), 0, 5'd0, 1, 0, 0,
         32'h0020A023);
    step(0, '0, 0, 5'd0, 0, 0, 0, $urandom);
    step(0, '0, 1, 5'd0, 0, 0, 0, $urandom);
    step(0, mk(0,0,1,0,1,0,2'd0,0,0,0), 1, 5'd0, 0, 0, 0, $urandom);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    reset_check("midrst");
    @(negedge clk);
    #2;
    reset_check("midrst_hold");
    release_reset();

    for (int i = 0; i < 300; i++) begin
      run($urandom_range(0, 3) == 0, rand_instr(),
          $urandom_range(0, 3), $urandom_range(0, 3), rb());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter INSTR_WIDTH, 32, instruction width in bits.
REQ-002 Parameter ALU_OP_WIDTH, 4, ALU operation code width.
REQ-003 Parameter SUPPORT_SRAI, 1, when 0 the opcode 0010011 / func3 101 / func7 0100000 combination decodes as illegal.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 instruction  input  INSTR_WIDTH  instruction word from instruction memory, valid when imem_ack=1.
REQ-007 imem_ack  input  1  instruction memory accepted the request; instruction valid this cycle.
REQ-008 dmem_ack  input  1  data memory transfer complete this cycle.
REQ-009 alu_zero  input  1  ALU result equals zero, sampled in EXECUTE.
REQ-010 imem_req  output  1  instruction fetch request.
REQ-011 dmem_req  output  1  data memory request.
REQ-012 dmem_read_en / dmem_write_en  output  1 each  load / store qualifier of dmem_req.
REQ-013 alu_op  output  ALU_OP_WIDTH  ALU operation.
REQ-014 sel_bw_imm_rs2  output  1  0 = immediate, 1 = rs2.
REQ-015 regfile_write_enable  output  1  register file write strobe.
REQ-016 wr_back_sel  output  2  00 ALU, 01 memory, 10 PC+4, 11 immediate (LUI).
REQ-017 ir_write / pc_write  output  1 each  instruction register load / PC update strobe.
REQ-018 pc_src  output  1  0 = PC+4, 1 = PC+immediate.
REQ-019 illegal_instr  output  1  one-cycle pulse on undecodable instruction.

Function
REQ-020 States SHALL be FETCH, DECODE, EXECUTE, MEM, WRITEBACK.
REQ-021 FETCH: imem_req=1, held until imem_ack; on the ack cycle ir_write=1 and next state DECODE; otherwise stay in FETCH.
REQ-022 DECODE SHALL latch opcode/func3/func7 from the stored instruction and go to EXECUTE, or for an illegal opcode pulse illegal_instr, pulse pc_write with pc_src=0, and go to FETCH.
REQ-023 Supported opcodes: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011 (func3 000 beq, 001 bne; other func3 illegal), JAL 1101111, LUI 0110111.
REQ-024 ALU codes: add 0, sub 1, sll 2, slt 3, sltu 4, xor 5, srl 6, sra 7, or 8, and 9; R/I-ALU map by func3/func7; func7 other than 0000000/0100000 on shift or add/sub is illegal.
REQ-025 LOAD/STORE SHALL use add with sel_bw_imm_rs2=0; BRANCH SHALL use sub with sel_bw_imm_rs2=1.
REQ-026 EXECUTE transitions: R, I-ALU, LUI, JAL -> WRITEBACK; LOAD, STORE -> MEM; BRANCH -> FETCH with pc_write=1 and pc_src=1 when taken (beq with alu_zero=1, bne with alu_zero=0), else pc_src=0.
REQ-027 MEM: dmem_req=1 with dmem_read_en (load) or dmem_write_en (store), held until dmem_ack; load -> WRITEBACK, store -> FETCH with pc_write=1, pc_src=0.
REQ-028 WRITEBACK: regfile_write_enable=1 for exactly one cycle, wr_back_sel per REQ-016, pc_write=1 (pc_src=1 for JAL, else 0), next FETCH.
REQ-029 Latency with zero-wait memories: R/I-ALU/LUI/JAL 4 cycles, LOAD 5, STORE 4, BRANCH 3; each ack wait cycle adds one.
REQ-030 Outputs SHALL be decoded from state plus latched fields only; instruction is ignored outside the imem_ack cycle.
REQ-031 An ack outside its request state SHALL be ignored.
REQ-032 Exactly one pc_write pulse per instruction, including illegal ones.

Reset
REQ-033 rst_n low SHALL force FETCH asynchronously; all strobes, requests and illegal_instr 0; alu_op 0; wr_back_sel 00; sel_bw_imm_rs2 1; latched fields 0.
REQ-034 Reset mid-transaction SHALL drop imem_req/dmem_req immediately; a fetch restarts one cycle after rst_n deasserts.

Structure
REQ-035 Opcode constants, ALU op enum, state enum and wr_back_sel encodings SHALL reside in shared package riscv_ctrl_pkg.
REQ-036 Combinational field decode SHALL be a sub-module alu_decoder (opcode, func3, func7 -> alu_op, sel_bw_imm_rs2, illegal).

Verification
REQ-037 add x3,x1,x2 (0x002081B3), imem_ack immediately -> regfile_write_enable in cycle 4, alu_op 0, wr_back_sel 00.
REQ-038 lw (0x0000A183), dmem_ack delayed 3 cycles -> dmem_req/dmem_read_en held 4 cycles, write-back in cycle 8, wr_back_sel 01.
REQ-039 beq (0x00208463) with alu_zero=1 -> pc_write with pc_src=1 in cycle 3, no regfile write; alu_zero=0 -> pc_src=0.
REQ-040 Opcode 0x7F -> illegal_instr pulse in DECODE, single pc_write, back in FETCH next cycle.
REQ-041 rst_n asserted during MEM of sw (0x0020A023) -> dmem_req drops same cycle, no pc_write, imem_req reasserts after release.
REQ-042 SUPPORT_SRAI=0, srai (0x4020D093) -> illegal_instr; SUPPORT_SRAI=1 -> alu_op 7.
